// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for RISC-V M-extension ops in EX: holds one op, stalls the pipeline,
// drives an external pipelined multiplier and runs an internal restoring divider.
module muldiv_seq_ctrl #(
  parameter int MUL_LATENCY = 2,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic [2:0]  mul_op_o,
  input  logic [31:0] mul_result_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_result_o,
  output logic [4:0]  resp_rd_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_WAIT = 3'd1,
    DIV_RUN  = 3'd2,
    DIV_FIX  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic [31:0]      rem_q;
  logic [31:0]      quo_q;
  logic [31:0]      dvsr_q;
  logic             neg_q_q;
  logic             neg_r_q;

  logic        accept;
  logic        req_signed;
  logic        div_by_zero;
  logic        div_ovf;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] special_res;

  logic [32:0] rem_sh;
  logic        step_borrow;
  logic [31:0] step_diff;
  logic [31:0] fix_quo;
  logic [31:0] fix_rem;

  assign accept      = (state == IDLE) && req_valid_i && !flush_i;
  assign req_signed  = ~req_op_i[0];
  assign div_by_zero = (req_b_i == 32'd0);
  assign div_ovf     = req_signed && (req_a_i == 32'h8000_0000) && (req_b_i == 32'hFFFF_FFFF);

  // Operand conditioning and the two results that skip the iterative divider.
  always_comb begin
    abs_a       = req_a_i;
    abs_b       = req_b_i;
    special_res = 32'd0;
    if (req_signed && req_a_i[31]) abs_a = 32'd0 - req_a_i;
    if (req_signed && req_b_i[31]) abs_b = 32'd0 - req_b_i;
    if (div_by_zero) special_res = req_op_i[1] ? req_a_i : 32'hFFFF_FFFF;
    else if (div_ovf) special_res = req_op_i[1] ? 32'd0 : 32'h8000_0000;
  end

  // One restoring step: the shifted partial remainder needs 33 bits when the divisor is large.
  always_comb begin
    rem_sh      = {rem_q, quo_q[31]};
    step_borrow = (rem_sh < {1'b0, dvsr_q});
    step_diff   = rem_sh[31:0] - dvsr_q;
    fix_quo     = neg_q_q ? (32'd0 - quo_q) : quo_q;
    fix_rem     = neg_r_q ? (32'd0 - rem_q) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall_o      = 1'b0;
    resp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!req_op_i[2])                state_nxt = MUL_WAIT;
          else if (div_by_zero || div_ovf) state_nxt = DONE;
          else                             state_nxt = DIV_RUN;
        end
      end
      MUL_WAIT: if (cnt == '0) state_nxt = DONE;
      DIV_RUN:  if (cnt == '0) state_nxt = DIV_FIX;
      DIV_FIX:  state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    stall_o      = !flush_i && (accept || (state == MUL_WAIT) ||
                                (state == DIV_RUN) || (state == DIV_FIX));
    resp_valid_o = (state == DONE) && !flush_i;
    if (flush_i) state_nxt = IDLE;
  end

  // Datapath registers; a flush freezes them so a killed op leaves no trace in resp_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      op_q          <= 3'd0;
      rd_q          <= 5'd0;
      rem_q         <= 32'd0;
      quo_q         <= 32'd0;
      dvsr_q        <= 32'd0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      mul_a_o       <= 32'd0;
      mul_b_o       <= 32'd0;
      mul_op_o      <= 3'd0;
      busy_o        <= 1'b0;
      resp_result_o <= 32'd0;
      resp_rd_o     <= 5'd0;
    end else begin
      busy_o <= (state_nxt != IDLE);
      if (!flush_i) begin
        case (state)
          IDLE: begin
            if (accept) begin
              op_q <= req_op_i;
              rd_q <= req_rd_i;
              if (!req_op_i[2]) begin
                mul_a_o  <= req_a_i;
                mul_b_o  <= req_b_i;
                mul_op_o <= req_op_i;
                cnt      <= CNT_W'(MUL_LATENCY - 1);
              end else if (div_by_zero || div_ovf) begin
                resp_result_o <= special_res;
                resp_rd_o     <= req_rd_i;
              end else begin
                rem_q   <= 32'd0;
                quo_q   <= abs_a;
                dvsr_q  <= abs_b;
                neg_q_q <= req_signed && (req_a_i[31] ^ req_b_i[31]);
                neg_r_q <= req_signed && req_a_i[31];
                cnt     <= CNT_W'(31);
              end
            end
          end
          MUL_WAIT: begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              resp_result_o <= mul_result_i;
              resp_rd_o     <= rd_q;
            end
          end
          DIV_RUN: begin
            cnt <= cnt - CNT_W'(1);
            if (step_borrow) begin
              rem_q <= rem_sh[31:0];
              quo_q <= {quo_q[30:0], 1'b0};
            end else begin
              rem_q <= step_diff;
              quo_q <= {quo_q[30:0], 1'b1};
            end
          end
          DIV_FIX: begin
            resp_result_o <= op_q[1] ? fix_rem : fix_quo;
            resp_rd_o     <= rd_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
